// File: rtl/axi_ad9265_delay_calib.sv
// AD9265 IO-delay calibration sequencer: sweeps a common tap across all lanes, finds the widest
// PN-clean window and programs its centre. Optional write watchdog: AXI_AD9265_DELAY_CALIB_TIMEOUT_EN.
module axi_ad9265_delay_calib #(
  parameter int unsigned NUM_LANES      = 9,
  parameter logic [5:0]  BASE_ADDRESS   = 6'h02,
  parameter int unsigned SETTLE_CYCLES  = 64,
  parameter int unsigned OBSERVE_CYCLES = 256
) (
  input  logic        up_clk,
  input  logic        up_rstn,
  input  logic        calib_start,
  input  logic        pn_oos,
  input  logic        pn_err,
  output logic        up_wreq,
  output logic [13:0] up_waddr,
  output logic [31:0] up_wdata,
  input  logic        up_wack,
  output logic        calib_busy,
  output logic        calib_done,
  output logic        calib_fail,
  output logic [4:0]  calib_tap,
  output logic [5:0]  calib_window
);

  typedef enum logic [3:0] {
    StIdle, StWr, StAck, StSettle, StObs, StEval, StFwr, StFack, StDone
  } state_e;

  localparam logic [7:0]  LastLane   = 8'(NUM_LANES - 1);
  localparam logic [15:0] SettleLast = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] ObsLast    = 16'(OBSERVE_CYCLES - 1);

  state_e      state;
  logic [7:0]  lane;
  logic [4:0]  tap;
  logic [15:0] cnt;
  logic        obs_fail;
  logic [5:0]  cur_len;
  logic [4:0]  cur_start;
  logic [5:0]  best_len;
  logic [4:0]  best_start;
  logic [4:0]  tap_final;
  logic        fail_int;
`ifdef AXI_AD9265_DELAY_CALIB_TIMEOUT_EN
  logic [7:0]  wdog;
`endif

  // Window bookkeeping as it would stand after the current EVAL cycle.
  logic [5:0] pass_len;
  logic [4:0] pass_start;
  logic       take_best;
  logic [5:0] nbest_len;
  logic [4:0] nbest_start;
  logic [4:0] centre;
  logic       obs_acc;

  always_comb begin
    pass_len    = cur_len + 6'd1;
    pass_start  = (cur_len == 6'd0) ? tap : cur_start;
    take_best   = !obs_fail && (pass_len > best_len);
    nbest_len   = take_best ? pass_len : best_len;
    nbest_start = take_best ? pass_start : best_start;
    centre      = (nbest_len == 6'd0) ? 5'd0 :
                  5'({1'b0, nbest_start} + ((nbest_len - 6'd1) >> 1));
    obs_acc     = obs_fail | pn_oos | pn_err;
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state        <= StIdle;
      lane         <= 8'd0;
      tap          <= 5'd0;
      cnt          <= 16'd0;
      obs_fail     <= 1'b0;
      cur_len      <= 6'd0;
      cur_start    <= 5'd0;
      best_len     <= 6'd0;
      best_start   <= 5'd0;
      tap_final    <= 5'd0;
      fail_int     <= 1'b0;
      up_wreq      <= 1'b0;
      up_waddr     <= 14'd0;
      up_wdata     <= 32'd0;
      calib_busy   <= 1'b0;
      calib_done   <= 1'b0;
      calib_fail   <= 1'b0;
      calib_tap    <= 5'd0;
      calib_window <= 6'd0;
`ifdef AXI_AD9265_DELAY_CALIB_TIMEOUT_EN
      wdog         <= 8'd0;
`endif
    end else begin
      up_wreq <= 1'b0;
      unique case (state)
        StIdle: begin
          if (calib_start) begin
            calib_done <= 1'b0;
            calib_fail <= 1'b0;
            calib_busy <= 1'b1;
            tap        <= 5'd0;
            lane       <= 8'd0;
            best_len   <= 6'd0;
            best_start <= 5'd0;
            cur_len    <= 6'd0;
            cur_start  <= 5'd0;
            fail_int   <= 1'b0;
            // The request is registered on entry so WR is the wreq cycle.
            up_wreq    <= 1'b1;
            up_waddr   <= {BASE_ADDRESS, 8'd0};
            up_wdata   <= 32'd0;
            state      <= StWr;
          end
        end
        StWr: begin
`ifdef AXI_AD9265_DELAY_CALIB_TIMEOUT_EN
          wdog  <= 8'd0;
`endif
          state <= StAck;
        end
        StAck: begin
          if (up_wack) begin
            if (lane != LastLane) begin
              lane     <= lane + 8'd1;
              up_wreq  <= 1'b1;
              up_waddr <= {BASE_ADDRESS, lane + 8'd1};
              up_wdata <= {27'd0, tap};
              state    <= StWr;
            end else begin
              lane  <= 8'd0;
              cnt   <= 16'd0;
              state <= StSettle;
            end
          end
`ifdef AXI_AD9265_DELAY_CALIB_TIMEOUT_EN
          else if (wdog == 8'd254) begin
            best_len  <= 6'd0;
            tap_final <= 5'd0;
            fail_int  <= 1'b1;
            state     <= StDone;
          end else begin
            wdog <= wdog + 8'd1;
          end
`endif
        end
        StSettle: begin
          if (cnt == SettleLast) begin
            cnt      <= 16'd0;
            obs_fail <= 1'b0;
            state    <= StObs;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        StObs: begin
          obs_fail <= obs_acc;
          if (cnt == ObsLast) begin
            state <= StEval;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        StEval: begin
          best_len   <= nbest_len;
          best_start <= nbest_start;
          if (obs_fail) begin
            cur_len <= 6'd0;
          end else begin
            cur_len   <= pass_len;
            cur_start <= pass_start;
          end
          lane    <= 8'd0;
          up_wreq <= 1'b1;
          up_waddr <= {BASE_ADDRESS, 8'd0};
          if (tap != 5'd31) begin
            tap      <= tap + 5'd1;
            up_wdata <= {27'd0, tap + 5'd1};
            state    <= StWr;
          end else begin
            tap_final <= centre;
            fail_int  <= (nbest_len == 6'd0);
            up_wdata  <= {27'd0, centre};
            state     <= StFwr;
          end
        end
        StFwr: begin
`ifdef AXI_AD9265_DELAY_CALIB_TIMEOUT_EN
          wdog  <= 8'd0;
`endif
          state <= StFack;
        end
        StFack: begin
          if (up_wack) begin
            if (lane != LastLane) begin
              lane     <= lane + 8'd1;
              up_wreq  <= 1'b1;
              up_waddr <= {BASE_ADDRESS, lane + 8'd1};
              up_wdata <= {27'd0, tap_final};
              state    <= StFwr;
            end else begin
              lane  <= 8'd0;
              state <= StDone;
            end
          end
`ifdef AXI_AD9265_DELAY_CALIB_TIMEOUT_EN
          else if (wdog == 8'd254) begin
            best_len  <= 6'd0;
            tap_final <= 5'd0;
            fail_int  <= 1'b1;
            state     <= StDone;
          end else begin
            wdog <= wdog + 8'd1;
          end
`endif
        end
        StDone: begin
          calib_tap    <= tap_final;
          calib_window <= best_len;
          calib_fail   <= fail_int;
          calib_done   <= 1'b1;
          calib_busy   <= 1'b0;
          state        <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ad9265_delay_calib.sv
// Scoreboard bench for axi_ad9265_delay_calib: expected writes queued at launch, popped on up_wreq.
module tb_axi_ad9265_delay_calib;

  localparam int NumLanes = 9;

  logic        up_clk = 1'b0;
  logic        up_rstn;
  logic        calib_start;
  logic        pn_oos;
  logic        pn_err;
  logic        up_wreq;
  logic [13:0] up_waddr;
  logic [31:0] up_wdata;
  logic        up_wack;
  logic        calib_busy;
  logic        calib_done;
  logic        calib_fail;
  logic [4:0]  calib_tap;
  logic [5:0]  calib_window;

  int          checks = 0;
  int          errors = 0;
  logic [45:0] exp_q[$];
  logic [31:0] pass_mask = 32'hFFFF_FFFF;
  logic        oos_force = 1'b0;
  logic [4:0]  dly_tap = 5'd0;
  logic        pulse = 1'b0;
  int          ack_lat = 2;
  logic        withhold_en = 1'b0;
  logic        withheld_seen = 1'b0;

  always #5 up_clk = ~up_clk;

  axi_ad9265_delay_calib #(
    .NUM_LANES      (NumLanes),
    .BASE_ADDRESS   (6'h02),
    .SETTLE_CYCLES  (4),
    .OBSERVE_CYCLES (8)
  ) dut (
    .up_clk       (up_clk),
    .up_rstn      (up_rstn),
    .calib_start  (calib_start),
    .pn_oos       (pn_oos),
    .pn_err       (pn_err),
    .up_wreq      (up_wreq),
    .up_waddr     (up_waddr),
    .up_wdata     (up_wdata),
    .up_wack      (up_wack),
    .calib_busy   (calib_busy),
    .calib_done   (calib_done),
    .calib_fail   (calib_fail),
    .calib_tap    (calib_tap),
    .calib_window (calib_window)
  );

  // Emulated delay line: PN errors pulse whenever the programmed tap is outside the pass mask.
  always @(negedge up_clk) pulse <= ~pulse;
  assign pn_err = !pass_mask[dly_tap] && pulse;
  assign pn_oos = oos_force;

  always @(negedge up_clk) begin
    if (up_rstn && up_wreq) begin
      logic [45:0] e;
      dly_tap = up_wdata[4:0];
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected got addr=%h data=%h required no write", up_waddr, up_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({up_waddr, up_wdata} !== e)
          begin
            errors++;
            $display("FAIL write_seq got addr=%h data=%h required addr=%h data=%h",
                     up_waddr, up_wdata, e[45:32], e[31:0]);
          end
      end
    end
  end

  // Ack responder: one write outstanding, ack ack_lat cycles after the wreq cycle.
  initial begin
    up_wack = 1'b0;
    forever begin
      @(negedge up_clk);
      while (up_rstn && up_wreq) begin
        if (withhold_en && up_waddr[7:0] == 8'd4 && up_wdata[4:0] == 5'd3) begin
          withheld_seen = 1'b1;
          @(negedge up_clk);
        end else begin
          repeat (ack_lat) @(negedge up_clk);
          up_wack = 1'b1;
          @(negedge up_clk);
          up_wack = 1'b0;
        end
      end
    end
  end

  function automatic void model(input logic [31:0] m, output int win, output int tp);
    int cur = 0, cs = 0, best = 0, bs = 0;
    for (int t = 0; t < 32; t++) begin
      if (m[t]) begin
        if (cur == 0) cs = t;
        cur++;
        if (cur > best) begin best = cur; bs = cs; end
      end else cur = 0;
    end
    win = best;
    tp  = (best == 0) ? 0 : bs + (best - 1) / 2;
  endfunction

  task automatic calib_launch(input logic [31:0] m, input logic oos, input int lat,
                              input int max_wr);
    int w, tp, n;
    n = 0;
    model(oos ? 32'd0 : m, w, tp);
    pass_mask = m; oos_force = oos; ack_lat = lat;
    for (int t = 0; t < 32; t++)
      for (int l = 0; l < NumLanes; l++) begin
        if (n < max_wr) exp_q.push_back({6'h02, 8'(l), 27'd0, 5'(t)});
        n++;
      end
    for (int l = 0; l < NumLanes; l++) begin
      if (n < max_wr) exp_q.push_back({6'h02, 8'(l), 27'd0, 5'(tp)});
      n++;
    end
    @(negedge up_clk) calib_start = 1'b1;
    @(negedge up_clk) calib_start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!calib_done && n < 5000) begin @(negedge up_clk); n++; end
    checks++;
    if (!calib_done) begin errors++; $display("FAIL done_timeout got done=0 required done=1"); end
    checks++;
    if (exp_q.size() != 0 || calib_busy !== 1'b0) begin
      errors++;
      $display("FAIL done_state got pending=%0d busy=%b required 0 0", exp_q.size(), calib_busy);
    end
  endtask

  task automatic test_reset();
    up_rstn = 1'b0; calib_start = 1'b0;
    repeat (3) @(negedge up_clk);
    checks++;
    if ({up_wreq, up_waddr, up_wdata, calib_busy, calib_done, calib_fail, calib_tap,
         calib_window} !== '0) begin
      errors++; $display("FAIL reset_values got wreq=%b addr=%h data=%h busy=%b done=%b required 0",
                         up_wreq, up_waddr, up_wdata, calib_busy, calib_done);
    end
    up_rstn = 1'b1;
    repeat (3) @(negedge up_clk);
  endtask

  task automatic test_all_pass();
    calib_launch(32'hFFFF_FFFF, 1'b0, 2, 1000);
    checks++;
    if (calib_busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b required 1", calib_busy); end
    wait_done();
    checks++;
    if ({calib_window, calib_tap, calib_fail, calib_done} !== {6'd32, 5'd15, 1'b0, 1'b1}) begin
      errors++; $display("FAIL all_pass got win=%0d tap=%0d fail=%b done=%b required 32 15 0 1",
                         calib_window, calib_tap, calib_fail, calib_done);
    end
  endtask

  task automatic test_window();
    calib_launch(32'h000F_FF00, 1'b0, 2, 1000);
    wait_done();
    checks++;
    if ({calib_window, calib_tap, calib_fail} !== {6'd12, 5'd13, 1'b0}) begin
      errors++; $display("FAIL window_8_19 got win=%0d tap=%0d fail=%b required 12 13 0",
                         calib_window, calib_tap, calib_fail);
    end
  endtask

  task automatic test_two_windows();
    calib_launch(32'h001F_FC1C, 1'b0, 2, 1000);
    wait_done();
    checks++;
    if ({calib_window, calib_tap} !== {6'd11, 5'd15}) begin
      errors++; $display("FAIL two_windows got win=%0d tap=%0d required 11 15", calib_window, calib_tap);
    end
    calib_launch(32'h00F0_000F, 1'b0, 1, 1000);
    wait_done();
    checks++;
    if ({calib_window, calib_tap, calib_fail} !== {6'd4, 5'd1, 1'b0}) begin
      errors++; $display("FAIL tie_keeps_first got win=%0d tap=%0d fail=%b required 4 1 0",
                         calib_window, calib_tap, calib_fail);
    end
  endtask

  task automatic test_oos();
    calib_launch(32'hFFFF_FFFF, 1'b1, 2, 1000);
    wait_done();
    checks++;
    if ({calib_window, calib_tap, calib_fail, calib_done} !== {6'd0, 5'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL oos_fail got win=%0d tap=%0d fail=%b done=%b required 0 0 1 1",
                         calib_window, calib_tap, calib_fail, calib_done);
    end
    oos_force = 1'b0;
  endtask

  task automatic test_back_to_back();
    calib_launch(32'h0000_FFF0, 1'b0, 1, 1000);
    checks++;
    if (calib_done !== 1'b0) begin errors++; $display("FAIL done_cleared got %b required 0", calib_done); end
    wait_done();
    checks++;
    if ({calib_window, calib_tap} !== {6'd12, 5'd9}) begin
      errors++; $display("FAIL back_to_back got win=%0d tap=%0d required 12 9", calib_window, calib_tap);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    calib_launch(32'hFFFF_FFFF, 1'b0, 2, 1000);
    while (!(up_wreq && up_wdata[4:0] == 5'd6 && up_waddr[7:0] == 8'd8) && n < 5000) begin
      @(negedge up_clk); n++;
    end
    checks++;
    if (n >= 5000) begin errors++; $display("FAIL tap6_reach got timeout required tap 6 lane 8 write"); end
    repeat (2 + 1 + 4 + 3) @(negedge up_clk);
    up_rstn = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({up_wreq, up_waddr, up_wdata, calib_busy, calib_done, calib_fail, calib_tap,
         calib_window} !== '0) begin
      errors++; $display("FAIL midsweep_reset got busy=%b addr=%h data=%h required all 0",
                         calib_busy, up_waddr, up_wdata);
    end
    repeat (3) @(negedge up_clk);
    up_rstn = 1'b1;
    repeat (10) @(negedge up_clk);
    calib_launch(32'h0003_FF00, 1'b0, 2, 1000);
    repeat (100) @(negedge up_clk);
    calib_start = 1'b1;
    @(negedge up_clk) calib_start = 1'b0;
    checks++;
    if (calib_busy !== 1'b1 || calib_done !== 1'b0) begin
      errors++; $display("FAIL start_while_busy got busy=%b done=%b required 1 0", calib_busy, calib_done);
    end
    wait_done();
    checks++;
    if ({calib_window, calib_tap} !== {6'd10, 5'd12}) begin
      errors++; $display("FAIL after_reset got win=%0d tap=%0d required 10 12", calib_window, calib_tap);
    end
    repeat (20) @(negedge up_clk);
  endtask

`ifdef AXI_AD9265_DELAY_CALIB_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    withhold_en = 1'b1;
    calib_launch(32'hFFFF_FFFF, 1'b0, 2, 3 * NumLanes + 5);
    while (!withheld_seen && n < 5000) begin @(negedge up_clk); n++; end
    n = 0;
    while (!calib_done && n < 1000) begin @(negedge up_clk); n++; end
    checks++;
    if (n != 257) begin errors++; $display("FAIL timeout_latency got %0d required 257", n); end
    checks++;
    if ({calib_window, calib_tap, calib_fail, calib_done} !== {6'd0, 5'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL timeout_result got win=%0d tap=%0d fail=%b done=%b required 0 0 1 1",
                         calib_window, calib_tap, calib_fail, calib_done);
    end
    repeat (50) @(negedge up_clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_writes got pending=%0d required 0", exp_q.size()); end
    withhold_en = 1'b0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got no finish required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_all_pass();
    test_window();
    test_two_windows();
    test_oos();
    test_back_to_back();
    test_reset_mid();
`ifdef AXI_AD9265_DELAY_CALIB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
